// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 device-side responder.
package ft600_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2
  } bus_state_t;

  localparam int ERR_RD_EMPTY   = 0;
  localparam int ERR_WR_FULL    = 1;
  localparam int ERR_CONTENTION = 2;
  localparam int ERR_RD_NO_OE   = 3;

endpackage

// File: rtl/ft600_sync_fifo.sv
// First-word-fall-through FIFO: head is valid whenever count != 0.
// A push while full or a pop while empty is ignored; push+pop together keeps count.
module ft600_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ft600_chip_responder.sv
// FT600 device side of the 245 sync FIFO bus, backed by host-fed RX/TX FIFOs.
// Flags are registered-count based; host_in_ready drops at full with no same-cycle bypass.
module ft600_chip_responder
  import ft600_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    usb_rxf,
  output logic                    usb_txe,
  input  logic                    usb_oe_n,
  input  logic                    usb_rd_n,
  input  logic                    usb_wr_n,
  input  logic [DATA_WIDTH-1:0]   usb_ad_i,
  output logic [DATA_WIDTH-1:0]   usb_ad_o,
  output logic                    usb_ad_oe,
  input  logic                    host_in_valid,
  output logic                    host_in_ready,
  input  logic [DATA_WIDTH-1:0]   host_in_data,
  output logic                    host_out_valid,
  input  logic                    host_out_ready,
  output logic [DATA_WIDTH-1:0]   host_out_data,
  output logic [$clog2(DEPTH):0]  rx_level,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic [3:0]              err,
  input  logic                    err_clear
);

  bus_state_t            state;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  rx_full, rx_empty, tx_full, tx_empty;
  logic                  rx_pop;
  logic [3:0]            err_new;

  assign rx_pop = (state == DRIVE) && !usb_rd_n && !rx_empty;

  ft600_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (host_in_valid),
    .push_data (host_in_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  ft600_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (!usb_wr_n),
    .push_data (usb_ad_i),
    .pop       (host_out_ready),
    .head      (host_out_data),
    .count     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign usb_rxf        = rx_empty;
  assign usb_txe        = tx_full;
  assign host_in_ready  = !rx_full;
  assign host_out_valid = !tx_empty;
  assign usb_ad_o       = usb_ad_oe ? rx_head : '0;

  // One dead cycle (TURN) before the responder takes the bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      usb_ad_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          usb_ad_oe <= 1'b0;
          if (!usb_oe_n) state <= TURN;
        end
        TURN: begin
          if (!usb_oe_n) begin
            state     <= DRIVE;
            usb_ad_oe <= 1'b1;
          end else begin
            state     <= IDLE;
            usb_ad_oe <= 1'b0;
          end
        end
        DRIVE: begin
          if (usb_oe_n) begin
            state     <= IDLE;
            usb_ad_oe <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          usb_ad_oe <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    err_new                 = '0;
    err_new[ERR_RD_EMPTY]   = (state == DRIVE) && !usb_rd_n && rx_empty;
    err_new[ERR_WR_FULL]    = !usb_wr_n && tx_full;
    err_new[ERR_CONTENTION] = !usb_wr_n && usb_ad_oe;
    err_new[ERR_RD_NO_OE]   = !usb_rd_n && usb_oe_n;
  end

  // A clear coinciding with a fresh error keeps that error's bit set.
  always_ff @(posedge CLK) begin
    if (RST)            err <= '0;
    else if (err_clear) err <= err_new;
    else                err <= err | err_new;
  end

endmodule
